dac_sample_player: RTL and testbench
====================================

Name: dac_sample_player

Overview:
- Upstream feeder for the R2R DAC output stage.
- Accepts DAC codes from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents one code on the registered DAC output bus per programmable sample period, derived from the 10 MHz clk.
- Holds the last code and flags a sticky underrun when the FIFO runs dry.

Parameters:
- WIDTH, 4, DAC code width in bits (matches the R2R ladder).
- DEPTH, 8, FIFO depth in entries; must be a power of 2, at least 2.
- DIV_WIDTH, 8, width of the sample-period divider.

Ports:
- clk  input  1  system clock, 10 MHz nominal.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  sample code from producer.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full, combinational from occupancy only.
- enable  input  1  run sample playback.
- div  input  DIV_WIDTH  sample period is div+1 clk cycles.
- clear_underrun  input  1  single-cycle clear of the underrun flag.
- dac_out  output  WIDTH  registered code to the R2R DAC.
- sample_tick  output  1  one-cycle pulse, high in the cycle a new sample period starts at dac_out.
- underrun  output  1  sticky: a tick occurred with the FIFO empty.
- level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: all state updates on the rising edge of clk only; rst takes priority over all other inputs.
  - On reset: dac_out=0, sample_tick=0, underrun=0, level=0, in_ready=1, divider count=0, FIFO pointers=0. FIFO contents are don't-care.
  - Reset mid-operation discards all buffered samples.
- Push: a push occurs on a clk edge when in_valid && in_ready; in_data is written at the write pointer and the pointer wraps modulo DEPTH. in_data is ignored when in_ready=0.
- Divider:
  - While enable=0 the count is forced to 0, no ticks occur, and dac_out holds. The FIFO still accepts pushes.
  - While enable=1 the count increments each cycle. When count>=div, a tick event occurs and the count returns to 0.
  - The >= compare makes a mid-count reduction of div tick on the next cycle.
  - div=0 gives a tick every cycle.
  - First tick after enable rises: div+1 cycles later.
- Tick event (registered): on the edge, sample_tick<=1.
  - If level>0: dac_out<=FIFO[rd], read pointer advances with wrap.
  - If level==0: dac_out holds and underrun<=1.
  - sample_tick is 0 on all non-tick cycles.
- Latency: a sample pushed into an empty FIFO appears on dac_out at the first tick edge strictly after the push edge. There is no bypass: a push and a tick on the same edge with level==0 counts as an underrun, and the pushed sample waits for the next tick.
- Simultaneous push and pop: allowed when 0<level<DEPTH; level is unchanged.
  - At level==DEPTH, in_ready=0 so only the pop occurs; in_ready rises the next cycle.
- Level arithmetic: level = level + push - pop; it never exceeds DEPTH or drops below 0.
- Underrun: set has priority over clear_underrun on the same edge. Otherwise clear_underrun drives underrun to 0.
- Input changes: enable or div changes take effect on the next edge. Deasserting enable resets the divider count, so resuming restarts a full period.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 and enable=1 -> during and after reset dac_out=0, level=0, in_ready=1, underrun=0, no sample_tick. Repeat mid-stream with level=5 -> level=0 after the reset edge.
- Fill and ordering: enable=0, push 3,7,11,15,0,1,2,5 -> level=8, in_ready=0. A 9th push of 9 is not accepted. Set div=3, enable=1 -> sample_tick every 4 cycles, dac_out=3,7,11,15,0,1,2,5 in order, level decrements to 0.
- Underrun and hold: after the sequence above drains, continue 2 more ticks -> dac_out holds 5 and underrun=1. Pulse clear_underrun between ticks -> underrun=0, then set again at the next tick. clear_underrun coincident with a tick edge -> underrun stays 1.
- Concurrent push and pop: div=0, enable=1, level=4, push on every cycle -> level stays 4, dac_out tracks the input stream delayed by 4 samples, no underrun. From level=8 with in_valid held high -> the pop occurs, in_ready rises 1 cycle later.
- Empty push collision: level=0, push 6 on the tick edge -> underrun=1, dac_out unchanged. The next tick gives dac_out=6.
- Divider edges: div=255 -> tick period 256 cycles. Change div from 200 to 10 while count=50 -> tick on the next edge, then every 11 cycles. Toggle enable low for 3 cycles -> no ticks, and the first tick comes div+1 cycles after re-enable.

Source files
------------

// File: rtl/dac_sample_player.sv
// Sample feeder for the R2R DAC. Producer samples are buffered in a small FIFO
// and released one at a time on a programmable sample period.
module dac_sample_player #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 8,
   parameter int DIV_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   enable,
   input  logic [DIV_WIDTH-1:0]   div,
   input  logic                   clear_underrun,
   output logic [WIDTH-1:0]       dac_out,
   output logic                   sample_tick,
   output logic                   underrun,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]          LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]          LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [AW-1:0]        wr_ptr_reg;
   logic [AW-1:0]        rd_ptr_reg;
   logic [AW:0]          level_reg;
   logic [DIV_WIDTH-1:0] count_reg;
   logic [WIDTH-1:0]     dac_out_reg;
   logic                 sample_tick_reg;
   logic                 underrun_reg;

   logic tick;
   logic push;
   logic pop;

   // The >= compare lets a mid-period reduction of div fire on the next edge.
   assign tick     = enable && (count_reg >= div);
   assign in_ready = (level_reg != LVL_FULL);
   assign push     = in_valid && in_ready;
   // No bypass: a tick with an empty FIFO underruns even if a push lands on it.
   assign pop      = tick && (level_reg != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (!enable || tick) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + CNT_ONE;
      end
   end

   // Storage carries no reset so it can map onto distributed or block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_ONE;
            2'b01:   level_reg <= level_reg - LVL_ONE;
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dac_out_reg     <= '0;
         sample_tick_reg <= 1'b0;
         underrun_reg    <= 1'b0;
      end else begin
         sample_tick_reg <= tick;
         if (pop) begin
            dac_out_reg <= mem[rd_ptr_reg];
         end
         // A new underrun wins over a clear arriving on the same edge.
         if (tick && !pop) begin
            underrun_reg <= 1'b1;
         end else if (clear_underrun) begin
            underrun_reg <= 1'b0;
         end
      end
   end

   assign dac_out     = dac_out_reg;
   assign sample_tick = sample_tick_reg;
   assign underrun    = underrun_reg;
   assign level       = level_reg;
endmodule

// File: tb/tb_dac_sample_player.sv
// Bench for dac_sample_player: a cycle model whose FIFO queue doubles as the
// scoreboard, plus table vectors and hand-written period/corner sequences.
module tb_dac_sample_player;
   localparam int WIDTH     = 4;
   localparam int DEPTH     = 8;
   localparam int DIV_WIDTH = 8;
   localparam int LW        = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [WIDTH-1:0]     in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 enable;
   logic [DIV_WIDTH-1:0] div;
   logic                 clear_underrun;
   logic [WIDTH-1:0]     dac_out;
   logic                 sample_tick;
   logic                 underrun;
   logic [LW-1:0]        level;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #50 clk = ~clk;

   dac_sample_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .enable(enable), .div(div),
      .clear_underrun(clear_underrun), .dac_out(dac_out),
      .sample_tick(sample_tick), .underrun(underrun), .level(level)
   );

   // Reference model state; sb_q holds the samples the DUT should still emit.
   logic [WIDTH-1:0] sb_q[$];
   int               m_count = 0;
   logic [WIDTH-1:0] m_dac   = '0;
   logic             m_tick  = 1'b0;
   logic             m_under = 1'b0;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               exp_level;
      logic             exp_ready;
   } fill_vec_t;
   fill_vec_t fill_tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: predict the edge from pre-edge inputs, then compare #1 after it.
   task automatic step();
      bit do_push;
      bit do_tick;
      logic [LW-1:0] exp_level;
      logic          exp_ready;
      do_push = in_valid && (sb_q.size() < DEPTH);
      do_tick = enable && (m_count >= int'(div));
      @(posedge clk);
      if (rst) begin
         sb_q.delete();
         m_count = 0;
         m_dac   = '0;
         m_tick  = 1'b0;
         m_under = 1'b0;
      end else begin
         if (!enable || do_tick) m_count = 0;
         else m_count++;
         if (do_tick) begin
            if (sb_q.size() > 0) m_dac = sb_q.pop_front();
            else m_under = 1'b1;
         end else if (clear_underrun) begin
            m_under = 1'b0;
         end
         if (do_push) sb_q.push_back(in_data);
         m_tick = do_tick;
      end
      #1;
      cyc++;
      exp_level = LW'(sb_q.size());
      exp_ready = (sb_q.size() != DEPTH);
      tests++;
      if (dac_out !== m_dac || sample_tick !== m_tick || underrun !== m_under ||
          level !== exp_level || in_ready !== exp_ready) begin
         fails++;
         $display("FAIL model cycle %0d: dac %0d/%0d tick %0b/%0b underrun %0b/%0b level %0d/%0d ready %0b/%0b (got/expected)",
                  cyc, dac_out, m_dac, sample_tick, m_tick, underrun, m_under,
                  level, exp_level, in_ready, exp_ready);
      end
   endtask

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (sample_tick !== 1'b1 && n < limit);
      if (sample_tick !== 1'b1) check("tick_timeout", 32'(sample_tick), 1);
   endtask

   initial begin
      int n;
      logic [WIDTH-1:0] exp_out[8];

      fill_tbl[0] = '{4'd3,  1, 1'b1};
      fill_tbl[1] = '{4'd7,  2, 1'b1};
      fill_tbl[2] = '{4'd11, 3, 1'b1};
      fill_tbl[3] = '{4'd15, 4, 1'b1};
      fill_tbl[4] = '{4'd0,  5, 1'b1};
      fill_tbl[5] = '{4'd1,  6, 1'b1};
      fill_tbl[6] = '{4'd2,  7, 1'b1};
      fill_tbl[7] = '{4'd5,  8, 1'b0};
      fill_tbl[8] = '{4'd9,  8, 1'b0};
      exp_out = '{4'd3, 4'd7, 4'd11, 4'd15, 4'd0, 4'd1, 4'd2, 4'd5};

      // Reset with producer and playback active.
      rst = 1'b1; in_valid = 1'b1; in_data = 4'd9; enable = 1'b1;
      div = '0; clear_underrun = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_dac", 32'(dac_out), 0);
         check("rst_level", 32'(level), 0);
         check("rst_ready", 32'(in_ready), 1);
         check("rst_underrun", 32'(underrun), 0);
         check("rst_tick", 32'(sample_tick), 0);
      end
      rst = 1'b0; in_valid = 1'b0; enable = 1'b0;
      step();

      // Mid-stream reset with 5 buffered samples.
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = WIDTH'(i + 1);
         step();
      end
      check("mid_level_before", 32'(level), 5);
      rst = 1'b1;
      step();
      check("mid_rst_level", 32'(level), 0);
      check("mid_rst_ready", 32'(in_ready), 1);
      rst = 1'b0; in_valid = 1'b0;
      step();

      // Fill to full; the 9th push must be refused.
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = fill_tbl[i].data;
         step();
         check($sformatf("fill%0d_level", i), 32'(level), 32'(fill_tbl[i].exp_level));
         check($sformatf("fill%0d_ready", i), 32'(in_ready), 32'(fill_tbl[i].exp_ready));
      end
      in_valid = 1'b0;

      // Drain in order at div=3.
      div = 8'd3; enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_tick(20, n);
         check($sformatf("drain%0d_period", i), 32'(n), 4);
         check($sformatf("drain%0d_dac", i), 32'(dac_out), 32'(exp_out[i]));
         check($sformatf("drain%0d_level", i), 32'(level), 32'(7 - i));
      end

      // Underrun, hold, clear and set-over-clear priority.
      wait_tick(20, n);
      check("ur1_dac_hold", 32'(dac_out), 5);
      check("ur1_flag", 32'(underrun), 1);
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      check("ur_clear", 32'(underrun), 0);
      wait_tick(20, n);
      check("ur2_flag", 32'(underrun), 1);
      check("ur2_dac_hold", 32'(dac_out), 5);
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      check("ur_clear2", 32'(underrun), 0);
      step();
      step();
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      check("ur_prio_tick", 32'(sample_tick), 1);
      check("ur_prio_flag", 32'(underrun), 1);

      // Concurrent push and pop at level 4, div=0.
      enable = 1'b0; clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = WIDTH'(10 + i);
         step();
      end
      div = '0; enable = 1'b1;
      for (int j = 0; j < 12; j++) begin
         in_data = WIDTH'(14 + j);
         step();
         check($sformatf("cc%0d_dac", j), 32'(dac_out), 32'((10 + j) % 16));
         check($sformatf("cc%0d_level", j), 32'(level), 4);
      end
      check("cc_underrun", 32'(underrun), 0);

      // From full with in_valid held: only the pop happens.
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = WIDTH'(i);
         step();
      end
      check("full_level", 32'(level), 8);
      check("full_ready", 32'(in_ready), 0);
      enable = 1'b1;
      step();
      check("full_pop_level", 32'(level), 7);
      check("full_pop_ready", 32'(in_ready), 1);
      enable = 1'b0; in_valid = 1'b0;

      // Push into an empty FIFO on a tick edge.
      rst = 1'b1;
      step();
      rst = 1'b0; div = 8'd2; enable = 1'b1;
      wait_tick(20, n);
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      step();
      in_valid = 1'b1; in_data = 4'd6;
      step();
      in_valid = 1'b0;
      check("col_tick", 32'(sample_tick), 1);
      check("col_underrun", 32'(underrun), 1);
      check("col_dac", 32'(dac_out), 0);
      check("col_level", 32'(level), 1);
      wait_tick(20, n);
      check("col_next_period", 32'(n), 3);
      check("col_next_dac", 32'(dac_out), 6);

      // Divider at maximum.
      enable = 1'b0;
      step();
      div = 8'd255; enable = 1'b1;
      wait_tick(300, n);
      check("div255_first", 32'(n), 256);
      wait_tick(300, n);
      check("div255_period", 32'(n), 256);

      // Reduce div mid-count.
      enable = 1'b0;
      step();
      div = 8'd200; enable = 1'b1;
      for (int i = 0; i < 50; i++) step();
      div = 8'd10;
      step();
      check("div_shrink_tick", 32'(sample_tick), 1);
      wait_tick(30, n);
      check("div_shrink_period", 32'(n), 11);

      // Pause playback for 3 cycles; resume restarts a full period.
      for (int i = 0; i < 5; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("pause_no_tick", 32'(sample_tick), 0);
      end
      enable = 1'b1;
      wait_tick(30, n);
      check("resume_period", 32'(n), 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
